// File: rtl/step_clock_gen_pkg.sv
// step_clock_pkg: shared definitions for the step_clock_gen block.
//   state_t        : FSM state encoding of the processor-clock generator.
//   DEF_*          : default debounce, pulse-width, run-rate and counter sizes
//                    used by the top-level parameter list.
package step_clock_pkg;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        PULSE_HIGH = 2'd1,
        PULSE_LOW  = 2'd2,
        RUN_WAIT   = 2'd3
    } state_t;

    // 10 ms of stable level at 50 MHz before a key change is accepted.
    localparam int DEF_DEBOUNCE_CYCLES = 500000;
    localparam int DEF_HIGH_CYCLES     = 4;

    // Run-mode dwell between pulses: 1 Hz, 10 Hz, 100 Hz and near full speed.
    localparam int DEF_RATE0 = 50000000;
    localparam int DEF_RATE1 = 5000000;
    localparam int DEF_RATE2 = 500000;
    localparam int DEF_RATE3 = 8;

    // Wide enough for the largest of the debounce and rate counts.
    localparam int DEF_CNT_W = 26;

endpackage

// File: rtl/step_clock_gen_if.sv
// step_clock_gen_if: user-facing signals of the processor clock generator.
//   key_step_n  : raw step push-button, active-low, asynchronous
//   run_mode    : raw run/step switch, asynchronous (1 = run)
//   rate_sel    : run-mode rate select
//   halt        : synchronous stop request
//   proc_clock  : generated processor clock (registered)
//   step_pulse  : one-cycle strobe on each proc_clock rising edge
//   step_count  : number of processor cycles issued since reset
//   key_pressed : debounced button level
//   running     : generator is in, or pulsing out of, run mode
// The master modport drives the controls; the slave modport is the generator.
interface step_clock_gen_if;

    logic        key_step_n;
    logic        run_mode;
    logic [1:0]  rate_sel;
    logic        halt;
    logic        proc_clock;
    logic        step_pulse;
    logic [15:0] step_count;
    logic        key_pressed;
    logic        running;

    modport master (
        output key_step_n, run_mode, rate_sel, halt,
        input  proc_clock, step_pulse, step_count, key_pressed, running
    );

    modport slave (
        input  key_step_n, run_mode, rate_sel, halt,
        output proc_clock, step_pulse, step_count, key_pressed, running
    );

endinterface

// File: rtl/step_clock_gen_debounce_sync.sv
// debounce_sync: two-flop synchroniser plus debouncer for an active-low button.
//   clock, reset : board clock, asynchronous active-high reset
//   raw_n        : raw active-low button input, asynchronous to clock
//   level        : debounced level, 1 = pressed
//   press        : one-cycle strobe on each released-to-pressed transition
module debounce_sync #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int CNT_W           = 26
) (
    input  logic clock,
    input  logic reset,
    input  logic raw_n,
    output logic level,
    output logic press
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync_p0;
    logic             sync_p1;
    logic [CNT_W-1:0] cnt;
    logic             mismatch;

    assign mismatch = (~sync_p1) != level;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            // Synchroniser starts at the released (high) level so that
            // leaving reset never looks like a press.
            sync_p0 <= 1'b1;
            sync_p1 <= 1'b1;
            cnt     <= '0;
            level   <= 1'b0;
            press   <= 1'b0;
        end else begin
            sync_p0 <= raw_n;
            sync_p1 <= sync_p0;
            press   <= 1'b0;
            if (!mismatch) begin
                cnt <= '0;
            end else if (cnt == LAST) begin
                // This edge is the DEBOUNCE_CYCLES-th stable differing cycle.
                cnt   <= '0;
                level <= ~level;
                press <= ~level;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/step_clock_gen.sv
// step_clock_gen: clean processor clock from a bouncy step button or a
// free-running run mode.
//   clock, reset : board clock, asynchronous active-high reset
//   bus (slave)  : key_step_n, run_mode, rate_sel, halt in;
//                  proc_clock, step_pulse, step_count, key_pressed, running out
// Each processor cycle is HIGH_CYCLES high followed by at least HIGH_CYCLES
// low. All outputs come straight from flops.
module step_clock_gen
    import step_clock_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int HIGH_CYCLES     = DEF_HIGH_CYCLES,
    parameter int RATE0           = DEF_RATE0,
    parameter int RATE1           = DEF_RATE1,
    parameter int RATE2           = DEF_RATE2,
    parameter int RATE3           = DEF_RATE3,
    parameter int CNT_W           = DEF_CNT_W
) (
    input  logic            clock,
    input  logic            reset,
    step_clock_gen_if.slave bus
);

    localparam logic [CNT_W-1:0] HIGH_LOAD = CNT_W'(HIGH_CYCLES - 1);

    function automatic logic [CNT_W-1:0] rate_load(input logic [1:0] sel);
        case (sel)
            2'd0:    rate_load = CNT_W'(RATE0 - 1);
            2'd1:    rate_load = CNT_W'(RATE1 - 1);
            2'd2:    rate_load = CNT_W'(RATE2 - 1);
            default: rate_load = CNT_W'(RATE3 - 1);
        endcase
    endfunction

    logic             run_p0;
    logic             run_p1;
    logic             key_level;
    logic             press;
    state_t           state;
    state_t           state_d;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_d;
    logic             cnt_zero;
    logic             run_pulse;
    logic             run_pulse_d;
    logic             launch;
    logic             proc_clock_r;
    logic             step_pulse_r;
    logic             running_r;
    logic             running_d;
    logic [15:0]      step_count_r;

    // ---- stage 0: input synchronisation and key debounce ----
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            run_p0 <= 1'b0;
            run_p1 <= 1'b0;
        end else begin
            run_p0 <= bus.run_mode;
            run_p1 <= run_p0;
        end
    end

    debounce_sync #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .CNT_W           (CNT_W)
    ) u_key_debounce (
        .clock (clock),
        .reset (reset),
        .raw_n (bus.key_step_n),
        .level (key_level),
        .press (press)
    );

    // ---- stage 1: FSM ----
    assign cnt_zero = (cnt == '0);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_d;
    end

    always_comb begin
        state_d = state;
        unique case (state)
            IDLE: begin
                // Run mode outranks a simultaneous press; presses are
                // only ever taken here, so they are never queued.
                if (!bus.halt) begin
                    if (run_p1)     state_d = RUN_WAIT;
                    else if (press) state_d = PULSE_HIGH;
                end
            end
            PULSE_HIGH: if (cnt_zero) state_d = PULSE_LOW;
            PULSE_LOW: begin
                if (cnt_zero) begin
                    state_d = (run_pulse && run_p1 && !bus.halt) ? RUN_WAIT : IDLE;
                end
            end
            RUN_WAIT: begin
                if (bus.halt || !run_p1) state_d = IDLE;
                else if (cnt_zero)       state_d = PULSE_HIGH;
            end
        endcase
    end

    // Shared phase timer: reloaded on every state change, else counts down
    // to zero. rate_sel is only looked at on RUN_WAIT entry.
    always_comb begin
        cnt_d       = cnt;
        run_pulse_d = run_pulse;
        launch      = (state_d == PULSE_HIGH) && (state != PULSE_HIGH);
        if (state_d != state) begin
            case (state_d)
                PULSE_HIGH: begin
                    cnt_d       = HIGH_LOAD;
                    run_pulse_d = (state == RUN_WAIT);
                end
                PULSE_LOW: cnt_d = HIGH_LOAD;
                RUN_WAIT:  cnt_d = rate_load(bus.rate_sel);
                default:   cnt_d = '0;
            endcase
        end else if (!cnt_zero) begin
            cnt_d = cnt - 1'b1;
        end
        running_d = (state_d == RUN_WAIT) ||
                    (((state_d == PULSE_HIGH) || (state_d == PULSE_LOW)) && run_pulse_d);
    end

    // ---- stage 2: timer and output registers ----
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt          <= '0;
            run_pulse    <= 1'b0;
            proc_clock_r <= 1'b0;
            step_pulse_r <= 1'b0;
            running_r    <= 1'b0;
            step_count_r <= 16'h0000;
        end else begin
            cnt          <= cnt_d;
            run_pulse    <= run_pulse_d;
            proc_clock_r <= (state_d == PULSE_HIGH);
            step_pulse_r <= launch;
            running_r    <= running_d;
            step_count_r <= step_count_r + 16'(launch);
        end
    end

    assign bus.proc_clock  = proc_clock_r;
    assign bus.step_pulse  = step_pulse_r;
    assign bus.step_count  = step_count_r;
    assign bus.key_pressed = key_level;
    assign bus.running     = running_r;

endmodule
